// File: rtl/bnn_pkg.sv
// Shared BNN weight-load definitions: frame sizing, nibble width, TX state
// encoding and the reset weight values also used by the BNN core.
`default_nettype none

package bnn_pkg;
  localparam int NUM_NEURONS = 12;
  localparam int NIB_W       = 4;
  localparam int CNT_W       = $clog2(NUM_NEURONS + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LO   = 3'd2,
    ST_HI   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [2*NIB_W-1:0] RST_WEIGHT_BYTE = '0;
  localparam logic [NIB_W-1:0]   RST_NIBBLE      = '0;
endpackage

`default_nettype wire

// File: rtl/bnn_weight_stream_tx_if.sv
// Byte input, nibble output and status bundle of the weight-stream transmitter.
`default_nettype none

interface bnn_weight_stream_tx_if #(
  parameter int NIB_W = bnn_pkg::NIB_W,
  parameter int CNT_W = bnn_pkg::CNT_W
);
  logic               start;
  logic               abort;
  logic [2*NIB_W-1:0] byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic [NIB_W-1:0]   nib_out;
  logic               load_en;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sent_cnt;
  logic               rx_misaligned;

  modport master (
    output start, abort, byte_in, byte_valid,
    input  byte_ready, nib_out, load_en, busy, done, sent_cnt, rx_misaligned
  );

  modport slave (
    input  start, abort, byte_in, byte_valid,
    output byte_ready, nib_out, load_en, busy, done, sent_cnt, rx_misaligned
  );
endinterface

`default_nettype wire

// File: rtl/bnn_byte_fifo.sv
// Synchronous byte FIFO with flush; also exposes the entry behind the head,
// bypassing a same-cycle push when the head is the only stored entry.
`default_nettype none

module bnn_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         flush_i,
  input  wire logic         push_i,
  input  wire logic         pop_i,
  input  wire logic [W-1:0] din_i,
  output logic      [W-1:0] dout_o,
  output logic      [W-1:0] dnext_o,
  output logic              has_next_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;
  logic [AW-1:0] rd_next;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !flush_i && !empty_o;
  assign rd_next = rd_q + 1'b1;

  assign dout_o     = mem_q[rd_q];
  assign has_next_o = (count_q >= (AW+1)'(2)) || push_i;
  assign dnext_o    = (count_q >= (AW+1)'(2)) ? mem_q[rd_next] : din_i;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_i) count_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (do_push) wr_q <= wr_q + 1'b1;
        if (do_pop)  rd_q <= rd_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

`default_nettype wire

// File: rtl/bnn_weight_stream_tx.sv
// Weight-stream transmitter: buffers weight bytes and sends each as a low/high
// nibble pair with load_en, one frame of NUM_NEURONS bytes per start.
`default_nettype none

module bnn_weight_stream_tx #(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int FIFO_DEPTH  = 4,
  parameter int NIB_W       = bnn_pkg::NIB_W
) (
  input wire logic             clk,
  input wire logic             reset,
  bnn_weight_stream_tx_if.slave bus
);
  import bnn_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NEURONS);

  state_e             state_q;
  logic [NIB_W-1:0]   nib_q;
  logic               load_en_q, busy_q, done_q, mis_q;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [2*NIB_W-1:0] fifo_head, fifo_next;
  logic               fifo_has_next, fifo_full, fifo_empty;
  logic               push, pop;

  // abort outranks a simultaneous push: the byte is dropped, not flushed later
  assign push   = bus.byte_valid && !fifo_full && !bus.abort;
  assign pop    = (state_q == ST_HI) && !bus.abort;
  assign sent_d = sent_q + 1'b1;

  bnn_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(2*NIB_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (bus.abort),
    .push_i     (push),
    .pop_i      (pop),
    .din_i      (bus.byte_in),
    .dout_o     (fifo_head),
    .dnext_o    (fifo_next),
    .has_next_o (fifo_has_next),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      nib_q     <= RST_NIBBLE;
      load_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= '0;
      mis_q     <= 1'b0;
    end else begin
      load_en_q <= 1'b0;
      done_q    <= 1'b0;
      if (bus.abort) begin
        // LO nibble already consumed by the receiver, HI never arrives
        if (state_q == ST_HI) mis_q <= 1'b1;
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (bus.start) begin
            state_q <= ST_WAIT;
            busy_q  <= 1'b1;
            sent_q  <= '0;
          end
          ST_WAIT: if (!fifo_empty) begin
            state_q   <= ST_LO;
            load_en_q <= 1'b1;
            nib_q     <= fifo_head[NIB_W-1:0];
          end
          ST_LO: begin
            state_q   <= ST_HI;
            load_en_q <= 1'b1;
            nib_q     <= fifo_head[2*NIB_W-1:NIB_W];
          end
          ST_HI: begin
            sent_q <= sent_d;
            if (sent_d == LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (fifo_has_next) begin
              state_q   <= ST_LO;
              load_en_q <= 1'b1;
              nib_q     <= fifo_next[NIB_W-1:0];
            end else begin
              state_q <= ST_WAIT;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.byte_ready    = !fifo_full;
  assign bus.nib_out       = nib_q;
  assign bus.load_en       = load_en_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.sent_cnt      = sent_q;
  assign bus.rx_misaligned = mis_q;
endmodule

`default_nettype wire

// File: tb/tb_bnn_weight_stream_tx.sv
// Randomised and directed bench for bnn_weight_stream_tx against a queue-based
// model of the nibble stream.
`default_nettype none

module tb_bnn_weight_stream_tx;
  localparam int N     = 12;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bnn_weight_stream_tx_if #(.NIB_W(4), .CNT_W(4)) bus ();

  bnn_weight_stream_tx #(.NUM_NEURONS(N), .FIFO_DEPTH(DEPTH), .NIB_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: byte queue plus which nibble of the head is on the wire
  logic [7:0] q[$];
  int         m_ph;      // 0 none, 1 low nibble shown, 2 high nibble shown
  bit         m_active, m_done, m_busy, m_mis, m_load, last_acc;
  int         m_sent;
  logic [3:0] m_nib;
  int         load_seen, done_seen;

  task automatic model_step(input bit s, input bit a, input bit v, input logic [7:0] b);
    int         pre;
    bit         pd;
    logic [7:0] hd;
    pre      = q.size();
    last_acc = v && (pre < DEPTH) && !a;
    pd       = m_done;
    m_done   = 0;
    m_load   = 0;
    if (a) begin
      if (m_ph == 2) m_mis = 1;
      q.delete();
      m_active = 0;
      m_ph     = 0;
      m_busy   = 0;
    end else begin
      if (last_acc) q.push_back(b);
      if (pd) begin
        m_busy = 0;
      end else if (!m_active) begin
        if (s) begin
          m_active = 1;
          m_busy   = 1;
          m_sent   = 0;
        end
      end else if (m_ph == 0) begin
        if (pre > 0) begin
          hd = q[0]; m_ph = 1; m_load = 1; m_nib = hd[3:0];
        end
      end else if (m_ph == 1) begin
        hd = q[0]; m_ph = 2; m_load = 1; m_nib = hd[7:4];
      end else begin
        void'(q.pop_front());
        m_sent++;
        if (m_sent == N) begin
          m_active = 0; m_done = 1; m_ph = 0;
        end else if (q.size() > 0) begin
          hd = q[0]; m_ph = 1; m_load = 1; m_nib = hd[3:0];
        end else begin
          m_ph = 0;
        end
      end
    end
  endtask

  // Called at a negedge: drive, clock, then compare everything at the next negedge
  task automatic step(input bit s, input bit a, input bit v, input logic [7:0] b);
    bus.start = s; bus.abort = a; bus.byte_valid = v; bus.byte_in = b;
    check("byte_ready", 32'(bus.byte_ready), 32'(q.size() < DEPTH));
    @(posedge clk);
    model_step(s, a, v, b);
    @(negedge clk);
    check("load_en", 32'(bus.load_en), 32'(m_load));
    if (m_load) check("nib_out", 32'(bus.nib_out), 32'(m_nib));
    check("done", 32'(bus.done), 32'(m_done));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("sent_cnt", 32'(bus.sent_cnt), 32'(m_sent));
    check("rx_misaligned", 32'(bus.rx_misaligned), 32'(m_mis));
    if (bus.load_en) load_seen++;
    if (bus.done) done_seen++;
  endtask

  function automatic logic [7:0] frame_byte(input int i);
    return (i == 0) ? 8'hA5 : 8'(i - 1);
  endfunction

  int         idx, k, acc_cnt;
  bit         found, pulsed;
  logic [3:0] nib_hist [2];

  initial begin
    bus.start = 0; bus.abort = 0; bus.byte_valid = 0; bus.byte_in = '0;
    q.delete(); m_ph = 0; m_active = 0; m_done = 0; m_busy = 0; m_mis = 0;
    m_load = 0; m_sent = 0; m_nib = '0; load_seen = 0; done_seen = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
    check("rst_load_en", 32'(bus.load_en), 32'd0);
    check("rst_nib_out", 32'(bus.nib_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sent_cnt", 32'(bus.sent_cnt), 32'd0);
    check("rst_rx_misaligned", 32'(bus.rx_misaligned), 32'd0);
    reset = 1'b0;

    // Prefilled full-rate frame: A5 then 00.. streaming in behind it
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 1, frame_byte(idx));
      if (last_acc) idx++;
    end
    check("prefill_ready_low", 32'(bus.byte_ready), 32'd0);
    load_seen = 0; done_seen = 0; k = 0;
    for (int c = 0; c < 60 && done_seen == 0; c++) begin
      step(c == 0, 0, idx < 13, frame_byte(idx));
      if (last_acc) idx++;
      if (bus.load_en && k < 2) begin nib_hist[k] = bus.nib_out; k++; end
    end
    check("full_first_nib", 32'(nib_hist[0]), 32'h5);
    check("full_second_nib", 32'(nib_hist[1]), 32'hA);
    check("full_load_cycles", 32'(load_seen), 32'd24);
    check("full_sent_cnt", 32'(bus.sent_cnt), 32'd12);
    step(0, 0, 0, 8'h00);
    check("full_busy_after", 32'(bus.busy), 32'd0);
    check("full_done_count", 32'(done_seen), 32'd1);

    // Empty FIFO start, late byte: two-edge latency then back to waiting
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    repeat (5) step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h3C);
    check("lat_accepted", 32'(last_acc), 32'd1);
    check("lat_edge1_load", 32'(bus.load_en), 32'd0);
    step(0, 0, 0, 8'h00);
    check("lat_lo_load", 32'(bus.load_en), 32'd1);
    check("lat_lo_nib", 32'(bus.nib_out), 32'hC);
    step(0, 0, 0, 8'h00);
    check("lat_hi_nib", 32'(bus.nib_out), 32'h3);
    step(0, 0, 0, 8'h00);
    check("lat_gap_load", 32'(bus.load_en), 32'd0);
    check("lat_gap_busy", 32'(bus.busy), 32'd1);
    step(0, 1, 0, 8'h00);

    // Prefill with no start: exactly DEPTH accepted, contents kept for the frame
    acc_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 1, 8'($urandom));
      if (last_acc) acc_cnt++;
    end
    check("hold_accepted", 32'(acc_cnt), 32'd4);
    check("hold_ready_low", 32'(bus.byte_ready), 32'd0);
    done_seen = 0;
    for (int c = 0; c < 200 && done_seen == 0; c++)
      step(c == 0, 0, ($urandom % 3) != 0, 8'($urandom));
    check("hold_frame_done", 32'(done_seen), 32'd1);

    // Abort in HI after the low nibble of 0x7E
    step(0, 1, 0, 8'h00);
    step(1, 0, 1, 8'h7E);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      step(0, 0, 0, 8'h00);
      if (bus.load_en && bus.nib_out == 4'hE) found = 1;
    end
    check("abort_lo_seen", 32'(found), 32'd1);
    step(0, 0, 0, 8'h00);
    done_seen = 0;
    step(1, 1, 1, 8'h55);
    check("abort_misaligned", 32'(bus.rx_misaligned), 32'd1);
    check("abort_load_off", 32'(bus.load_en), 32'd0);
    check("abort_fifo_empty", 32'(bus.byte_ready), 32'd1);
    step(0, 0, 0, 8'h00);
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle", 32'(bus.busy), 32'd0);

    // Start pulsed mid-frame is ignored
    done_seen = 0; pulsed = 0;
    for (int c = 0; c < 300 && done_seen == 0; c++) begin
      step(c == 0 || (!pulsed && bus.sent_cnt == 4'd5), 0,
           ($urandom % 5) != 0, 8'($urandom));
      if (c > 0 && bus.sent_cnt == 4'd5) pulsed = 1;
    end
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    check("midstart_done_once", 32'(done_seen), 32'd1);
    check("midstart_sent", 32'(bus.sent_cnt), 32'd12);

    // Random soak
    for (int c = 0; c < 500; c++)
      step(($urandom % 20) == 0, ($urandom % 70) == 0,
           ($urandom % 4) != 0, 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/bnn_weight_stream_tx.md
Name: bnn_weight_stream_tx

Overview:
- Transmit end of the BNN weight-load interface. Accepts weight bytes over a valid/ready port and buffers them in a small FIFO.
- Serialises each byte as two 4-bit nibbles, low nibble first, on nib_out with load_en high. This drives the nibble/load-enable pins of the BNN core.
- Sends one frame of exactly NUM_NEURONS bytes per start, then pulses done.
- Used by the on-chip self-test sequencer and the FPGA harness to reload all neuron weights.

Parameters:
NUM_NEURONS, 12, bytes (neurons) per frame
FIFO_DEPTH, 4, input byte buffer entries (power of 2, >=2)
NIB_W, 4, nibble width; byte width is 2*NIB_W

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins a frame when in IDLE
abort  in  1  terminate the frame, flush the FIFO
byte_in  in  8  weight byte (bit i = weight for input i)
byte_valid  in  1  byte_in valid
byte_ready  out  1  FIFO not full; a transfer occurs when byte_valid && byte_ready
nib_out  out  NIB_W  nibble to the receiver
load_en  out  1  nib_out valid this cycle
busy  out  1  frame in progress (state != IDLE)
done  out  1  one-cycle pulse after the last nibble of a frame
sent_cnt  out  4  bytes fully sent in the current or last frame
rx_misaligned  out  1  sticky: a frame was aborted between the low and high nibble

Behaviour:
- Reset values:
  - nib_out=0, load_en=0, busy=0, done=0, sent_cnt=0, rx_misaligned=0.
  - FIFO is empty, so byte_ready=1. State is IDLE.
- All outputs are registered except byte_ready, which is combinational: it is the inverse of fifo_full.
- FIFO:
  - Accepts bytes in any state, including IDLE, so the FIFO can be prefilled.
  - Pop and push in the same cycle when full is legal; count is unchanged and byte_ready stays 0 that cycle.
- State machine:
  - IDLE: start -> WAIT; sent_cnt cleared on start. A start pulse in any other state is ignored.
  - WAIT: FIFO non-empty -> LO; otherwise stay. load_en=0.
  - LO: load_en=1, nib_out=head[3:0]. Always -> HI next cycle.
  - HI: load_en=1, nib_out=head[7:4]. Pop the head; sent_cnt+1.
    - If sent_cnt+1==NUM_NEURONS -> DONE.
    - Else if the FIFO still holds another byte after the pop -> LO directly, with no bubble.
    - Else -> WAIT.
  - DONE: load_en=0, done=1 for this cycle only -> IDLE.
- Nibble pairs are never split by a gap. The LO->HI transition is unconditional, so load_en is high for exactly 2 consecutive cycles per byte.
- Gaps are allowed between bytes; the receiver tolerates them.
- Latency: the first LO nibble appears on the 2nd rising edge after the byte is accepted, when the FIFO was empty and the state was WAIT.
- Full-rate frame with a prefilled FIFO: 2*NUM_NEURONS consecutive load_en cycles.
- Bytes left in the FIFO after DONE are retained for the next frame.
- abort (any state): next state IDLE, load_en=0, FIFO flushed.
  - sent_cnt holds its value.
  - No done pulse.
  - If the state was HI at the abort edge, rx_misaligned is set. The LO nibble has already been consumed by the receiver, but the HI nibble is not delivered.
  - abort takes priority over start and over a simultaneous FIFO push; the pushed byte is dropped.
- rx_misaligned clears only on reset; the receiver must also be reset to realign.
- Reset mid-frame: immediate return to reset values. The receiver is expected to be reset by the same reset.

Decomposition:
- Shared package bnn_pkg holds:
  - NUM_NEURONS
  - NIB_W
  - CNT_W = clog2(NUM_NEURONS+1)
  - state encoding enum {IDLE, WAIT, LO, HI, DONE}
  - reset weight constants, shared with the BNN core.
- One sub-module, bnn_byte_fifo: synchronous FIFO with parameter DEPTH and ports push, pop, din, dout (head), full, empty, flush.
- The FSM and counters live in the top module.

Test Plan:
- Reset -> byte_ready=1, load_en=0, busy=0, sent_cnt=0, rx_misaligned=0.
- Push 0xA5 (4 prefilled bytes, FIFO_DEPTH=4), then start; keep byte_valid high with bytes 0x00..0x0B so the rest of the frame streams in -> nib_out sequence 5,A,... with load_en high for 24 cycles.
  - Also check: done pulses exactly once, sent_cnt=12, busy=0 on the following cycle.
- Start with the FIFO empty, then push 0x3C after 5 idle cycles -> load_en rises 2 edges after acceptance with nib_out=C, then 3; state returns to WAIT between bytes.
- Hold byte_valid=1 with start absent -> 4 bytes accepted, then byte_ready=0; the FIFO contents are preserved until a frame pops them.
- Abort while in HI after the LO nibble of byte 0x7E (nib_out=E shown) -> rx_misaligned=1, load_en=0 next cycle, FIFO empty, no done pulse.
- Start pulsed during byte 5 of a frame -> ignored; the frame ends normally at 12 bytes with a single done pulse.
